// File: rtl/dmem_pkg.sv
// Shared types and helpers for the RV32 data memory controller.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        S_CLEAR,
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    // size is funct3[1:0]: 00 byte, 01 half, 10 word
    function automatic logic is_aligned(
        input logic [1:0] size,
        input logic [1:0] alo
    );
        unique case (size)
            2'b00:   return 1'b1;
            2'b01:   return ~alo[0];
            2'b10:   return alo == 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Lane steering: load extract/extend and store byte-enable/replication.
import dmem_pkg::*;

module dmem_lane_align (
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_rword,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_load,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = 8'(i_rword >> {i_addr_lo, 3'b000});
    assign w_half = i_addr_lo[1] ? i_rword[31:16] : i_rword[15:0];

    always_comb begin
        o_load = i_rword;
        unique case (i_funct3)
            F3_B:    o_load = {{24{w_byte[7]}}, w_byte};
            F3_BU:   o_load = {24'd0, w_byte};
            F3_H:    o_load = {{16{w_half[15]}}, w_half};
            F3_HU:   o_load = {16'd0, w_half};
            default: o_load = i_rword;
        endcase
    end

    // Data is replicated across lanes so the enable alone picks the bytes
    always_comb begin
        o_be    = 4'b1111;
        o_wdata = i_wdata;
        case (i_funct3[1:0])
            2'b00: begin
                o_be    = 4'b0001 << i_addr_lo;
                o_wdata = {4{i_wdata[7:0]}};
            end
            2'b01: begin
                o_be    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_wdata = {2{i_wdata[15:0]}};
            end
            default: begin
                o_be    = 4'b1111;
                o_wdata = i_wdata;
            end
        endcase
    end

endmodule

// File: rtl/data_memory_ctrl.sv
// RV32IM MEM-stage data memory with fixed access latency, fault flag
// and a post-reset clear sweep.
import dmem_pkg::*;

module data_memory_ctrl #(
    parameter int DEPTH_BYTES    = 1024,
    parameter int ACCESS_LATENCY = 2,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        READ,
    input  logic        WRITE,
    input  logic [2:0]  FUNCT3,
    input  logic [31:0] ADDRESS,
    input  logic [31:0] WRITEDATA,
    output logic [31:0] READDATA,
    output logic        BUSYWAIT,
    output logic        FAULT
);

    localparam int AW = $clog2(DEPTH_BYTES);
    localparam int WW = AW - 2;
    localparam int CW = $clog2(ACCESS_LATENCY + 1);
    localparam logic [WW-1:0] LAST_W = WW'(DEPTH_BYTES / 4 - 1);
    localparam logic [CW-1:0] LAT    = CW'(ACCESS_LATENCY);
    localparam state_t RST_STATE =
        (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;

    reg [7:0] mem [0:DEPTH_BYTES-1];

    state_t        r_state, w_next;
    logic [CW-1:0] r_cnt;
    logic [WW-1:0] r_clr;
    logic          r_rd, r_wr;
    logic [2:0]    r_f3;
    logic [31:0]   r_addr, r_wdata;
    logic [31:0]   r_rdata;
    logic          r_fault;

    logic          w_req, w_last, w_fire, w_fault, w_f3_ok;
    logic [WW-1:0] w_word;
    logic [31:0]   w_rword, w_load, w_wsh;
    logic [3:0]    w_be;

    assign w_req  = READ | WRITE;
    assign w_last = r_cnt == CW'(1);
    assign w_fire = (r_state == S_WAIT) && w_last;
    assign w_word = r_addr[AW-1:2];

    assign w_f3_ok = r_wr ? (r_f3 inside {F3_B, F3_H, F3_W})
                          : (r_f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});

    // Full 32-bit range compare: no aliasing of high addresses
    assign w_fault = (r_rd & r_wr)
                   | (r_addr >= 32'(DEPTH_BYTES))
                   | ~is_aligned(r_f3[1:0], r_addr[1:0])
                   | ~w_f3_ok;

    assign w_rword = {mem[{w_word, 2'd3}], mem[{w_word, 2'd2}],
                      mem[{w_word, 2'd1}], mem[{w_word, 2'd0}]};

    dmem_lane_align u_align (
        .i_funct3  (r_f3),
        .i_addr_lo (r_addr[1:0]),
        .i_rword   (w_rword),
        .i_wdata   (r_wdata),
        .o_load    (w_load),
        .o_be      (w_be),
        .o_wdata   (w_wsh)
    );

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) r_state <= RST_STATE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        BUSYWAIT = 1'b1;
        unique case (r_state)
            S_CLEAR: if (r_clr == LAST_W) w_next = S_IDLE;
            S_IDLE: begin
                BUSYWAIT = w_req;
                if (w_req) w_next = S_WAIT;
            end
            S_WAIT: if (w_last) w_next = S_DONE;
            S_DONE: begin
                BUSYWAIT = 1'b0;
                w_next   = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_cnt   <= '0;
            r_clr   <= '0;
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            r_f3    <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_fault <= 1'b0;
        end else begin
            if (r_state == S_CLEAR) r_clr <= r_clr + WW'(1);
            if (r_state == S_IDLE && w_req) begin
                r_rd    <= READ;
                r_wr    <= WRITE;
                r_f3    <= FUNCT3;
                r_addr  <= ADDRESS;
                r_wdata <= WRITEDATA;
                r_cnt   <= LAT;
            end
            if (r_state == S_WAIT) begin
                r_cnt <= r_cnt - CW'(1);
                if (w_last) begin
                    r_fault <= w_fault;
                    if (!w_fault && r_rd) r_rdata <= w_load;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (r_state == S_CLEAR) begin
            for (int k = 0; k < 4; k++) mem[{r_clr, 2'(k)}] <= 8'd0;
        end else if (w_fire && !w_fault && r_wr) begin
            for (int k = 0; k < 4; k++)
                if (w_be[k]) mem[{w_word, 2'(k)}] <= w_wsh[8*k +: 8];
        end
    end

    assign READDATA = r_rdata;
    assign FAULT    = r_fault;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed bench: three controllers (latency 2 with clear, 1 and 3
// without) share address/data; each has its own READ/WRITE.
module tb_data_memory_ctrl;
    import dmem_pkg::*;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic [2:0]  f3;
    logic [31:0] addr, wdata;
    logic        rd [3];
    logic        wr [3];
    logic [31:0] rdata [3];
    logic        busy [3];
    logic        fault [3];

    int n_chk = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    data_memory_ctrl #(.DEPTH_BYTES(1024), .ACCESS_LATENCY(2),
                       .CLEAR_ON_RESET(1)) u0 (
        .CLK(CLK), .RESET_N(RESET_N), .READ(rd[0]), .WRITE(wr[0]),
        .FUNCT3(f3), .ADDRESS(addr), .WRITEDATA(wdata),
        .READDATA(rdata[0]), .BUSYWAIT(busy[0]), .FAULT(fault[0]));

    data_memory_ctrl #(.DEPTH_BYTES(1024), .ACCESS_LATENCY(1),
                       .CLEAR_ON_RESET(0)) u1 (
        .CLK(CLK), .RESET_N(RESET_N), .READ(rd[1]), .WRITE(wr[1]),
        .FUNCT3(f3), .ADDRESS(addr), .WRITEDATA(wdata),
        .READDATA(rdata[1]), .BUSYWAIT(busy[1]), .FAULT(fault[1]));

    data_memory_ctrl #(.DEPTH_BYTES(1024), .ACCESS_LATENCY(3),
                       .CLEAR_ON_RESET(0)) u2 (
        .CLK(CLK), .RESET_N(RESET_N), .READ(rd[2]), .WRITE(wr[2]),
        .FUNCT3(f3), .ADDRESS(addr), .WRITEDATA(wdata),
        .READDATA(rdata[2]), .BUSYWAIT(busy[2]), .FAULT(fault[2]));

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // cyc = index of the first cycle with BUSYWAIT low (request in cycle 0)
    task automatic acc(input int u, input logic r, input logic w,
                       input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] d, output int cyc);
        @(negedge CLK);
        rd[u] = r; wr[u] = w; f3 = f; addr = a; wdata = d;
        #1;
        cyc = 0;
        while (busy[u] && cyc < 60) begin
            @(negedge CLK);
            cyc++;
        end
        chk($sformatf("bw%0d", u), 32'(busy[u]), 0);
        @(posedge CLK);
        #1;
        rd[u] = 1'b0; wr[u] = 1'b0;
    endtask

    task automatic ld(input int u, input logic [2:0] f, input logic [31:0] a,
                      input logic [31:0] exp, input logic ef,
                      input string tag);
        int c;
        acc(u, 1'b1, 1'b0, f, a, 32'd0, c);
        chk(tag, rdata[u], exp);
        chk({tag, "_flt"}, 32'(fault[u]), 32'(ef));
    endtask

    task automatic st(input int u, input logic [2:0] f, input logic [31:0] a,
                      input logic [31:0] d, input logic ef, input string tag);
        int c;
        acc(u, 1'b0, 1'b1, f, a, d, c);
        chk({tag, "_flt"}, 32'(fault[u]), 32'(ef));
    endtask

    task automatic sweep(output int n);
        n = 0;
        #1;
        while (busy[0] && n < 1000) begin
            n++;
            @(negedge CLK);
        end
    endtask

    initial begin
        int n, c;
        for (int i = 0; i < 3; i++) begin
            rd[i] = 1'b0; wr[i] = 1'b0;
        end
        f3 = F3_W; addr = '0; wdata = '0;
        RESET_N = 1'b1;
        #2 RESET_N = 1'b0;
        repeat (3) @(negedge CLK);
        chk("rst_rdata", rdata[0], 0);
        chk("rst_fault", 32'(fault[0]), 0);
        chk("rst_busy0", 32'(busy[0]), 1);
        chk("rst_busy1", 32'(busy[1]), 0);

        RESET_N = 1'b1;
        sweep(n);
        chk("sweep1", n, 256);
        ld(0, F3_W, 32'h3FC, 32'h0, 1'b0, "lw_3fc");

        st(0, F3_W, 32'h10, 32'h8765_4321, 1'b0, "sw_10");
        ld(0, F3_W,  32'h10, 32'h8765_4321, 1'b0, "lw_10");
        ld(0, F3_B,  32'h10, 32'h0000_0021, 1'b0, "lb_10");
        ld(0, F3_B,  32'h13, 32'hFFFF_FF87, 1'b0, "lb_13");
        ld(0, F3_BU, 32'h13, 32'h0000_0087, 1'b0, "lbu_13");
        ld(0, F3_HU, 32'h12, 32'h0000_8765, 1'b0, "lhu_12");
        ld(0, F3_H,  32'h12, 32'hFFFF_8765, 1'b0, "lh_12");
        ld(0, F3_H,  32'h10, 32'h0000_4321, 1'b0, "lh_10");

        st(0, F3_B, 32'h11, 32'h0000_00AA, 1'b0, "sb_11");
        ld(0, F3_W, 32'h10, 32'h8765_AA21, 1'b0, "lw_10b");
        st(0, F3_H, 32'h16, 32'h1234_BEEF, 1'b0, "sh_16");
        ld(0, F3_W, 32'h14, 32'hBEEF_0000, 1'b0, "lw_14");

        ld(0, F3_W, 32'h12, 32'hBEEF_0000, 1'b1, "lw_mis");
        st(0, F3_H, 32'h01, 32'h0000_FFFF, 1'b1, "sh_mis");
        ld(0, F3_W, 32'h400, 32'hBEEF_0000, 1'b1, "lw_oor");
        st(0, F3_W, 32'h400, 32'h0000_CAFE, 1'b1, "sw_oor");
        ld(0, 3'b011, 32'h0, 32'hBEEF_0000, 1'b1, "ld_f3");
        st(0, 3'b100, 32'h1C, 32'h0000_0099, 1'b1, "st_f3");
        acc(0, 1'b1, 1'b1, F3_W, 32'h18, 32'h0000_0077, c);
        chk("rw_flt", 32'(fault[0]), 1);
        ld(0, F3_W, 32'h0,  32'h0, 1'b0, "lw_0");
        ld(0, F3_W, 32'h18, 32'h0, 1'b0, "lw_18");
        ld(0, F3_W, 32'h1C, 32'h0, 1'b0, "lw_1c");
        ld(0, F3_W, 32'h10, 32'h8765_AA21, 1'b0, "lw_10c");

        acc(1, 1'b0, 1'b1, F3_W, 32'h40, 32'h1122_3344, c);
        chk("lat1_sw", c, 2);
        acc(1, 1'b1, 1'b0, F3_W, 32'h40, 32'h0, c);
        chk("lat1_lw", c, 2);
        chk("lat1_data", rdata[1], 32'h1122_3344);
        acc(2, 1'b0, 1'b1, F3_W, 32'h40, 32'h1122_3344, c);
        chk("lat3_sw", c, 4);
        acc(2, 1'b1, 1'b0, F3_W, 32'h40, 32'h0, c);
        chk("lat3_lw", c, 4);
        chk("lat3_data", rdata[2], 32'h1122_3344);
        acc(0, 1'b1, 1'b0, F3_W, 32'h14, 32'h0, c);
        chk("lat2_lw", c, 3);

        // Request dropped after one WAIT cycle must still complete
        st(2, F3_W, 32'h44, 32'h5566_7788, 1'b0, "sw_44");
        @(negedge CLK);
        rd[2] = 1'b1; f3 = F3_W; addr = 32'h44;
        @(negedge CLK);
        rd[2] = 1'b0;
        n = 0;
        while (busy[2] && n < 60) begin
            @(negedge CLK);
            n++;
        end
        chk("drop_bw", 32'(busy[2]), 0);
        chk("drop_data", rdata[2], 32'h5566_7788);

        st(2, F3_W, 32'h20, 32'h0BAD_F00D, 1'b0, "sw2_20");
        ld(2, F3_W, 32'h20, 32'h0BAD_F00D, 1'b0, "lw2_20");
        ld(0, F3_W, 32'h12, 32'hBEEF_0000, 1'b1, "pre_rst");

        @(negedge CLK);
        wr[0] = 1'b1; wr[2] = 1'b1;
        f3 = F3_W; addr = 32'h20; wdata = 32'hDEAD_BEEF;
        @(negedge CLK);
        RESET_N = 1'b0;
        wr[0] = 1'b0; wr[2] = 1'b0;
        #1;
        chk("rst2_rdata0", rdata[0], 0);
        chk("rst2_fault0", 32'(fault[0]), 0);
        chk("rst2_busy0", 32'(busy[0]), 1);
        chk("rst2_rdata2", rdata[2], 0);
        repeat (2) @(negedge CLK);
        RESET_N = 1'b1;
        sweep(n);
        chk("sweep2", n, 256);
        ld(0, F3_W, 32'h20, 32'h0, 1'b0, "lw_20_rst");
        ld(0, F3_W, 32'h10, 32'h0, 1'b0, "lw_10_clr");
        ld(2, F3_W, 32'h20, 32'h0BAD_F00D, 1'b0, "lw2_20_rst");

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
